traffic_light_fsm: RTL and testbench

- Sequencing controller for the traffic-light datapath.
- Selects which timing interval (base, extended, yellow) the time-parameter store presents.
- Loads and counts down an internal seconds timer from the returned value.
- Steps the main/side/walk lights through a fixed phase sequence, modified by the side-street sensor and a latched walk request.

---
 rtl/traffic_light_fsm.sv | 110 +++++++++++
 tb/tb_traffic_light_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Phase sequencer for the traffic-light datapath: picks the timing interval,
// loads/counts the seconds timer and steps the main/side/walk lights.
module traffic_light_fsm #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one_hz_enable,
  input  logic             Prog_Sync,
  input  logic             Sensor_Sync,
  input  logic             WR_Sync,
  input  logic [CNT_W-1:0] value,
  output logic [1:0]       interval,
  output logic [6:0]       LEDs,
  output logic             walk_pending,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S0_MG1  = 3'd0,
    S1_MG2  = 3'd1,
    S2_MY   = 3'd2,
    S3_WALK = 3'd3,
    S4_SG1  = 3'd4,
    S5_SG2  = 3'd5,
    S6_SY   = 3'd6
  } state_t;

  localparam logic [1:0] IV_BASE = 2'b00;
  localparam logic [1:0] IV_EXT  = 2'b01;
  localparam logic [1:0] IV_YEL  = 2'b10;

  state_t           state_q, state_d;
  state_t           expire_nxt;
  logic             illegal;
  logic             load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             walk_q, walk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0_MG1;
      load_q  <= 1'b1;
      cnt_q   <= '0;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    cnt_d      = cnt_q;
    walk_d     = walk_q | WR_Sync;
    illegal    = 1'b0;
    expire_nxt = S0_MG1;

    case (state_q)
      S0_MG1:  expire_nxt = S1_MG2;
      S1_MG2:  expire_nxt = S2_MY;
      S2_MY:   expire_nxt = walk_q ? S3_WALK : S4_SG1;
      S3_WALK: expire_nxt = S4_SG1;
      S4_SG1:  expire_nxt = Sensor_Sync ? S5_SG2 : S6_SY;
      S5_SG2:  expire_nxt = S6_SY;
      S6_SY:   expire_nxt = S0_MG1;
      default: illegal    = 1'b1;
    endcase

    if (Prog_Sync || illegal) begin
      state_d = S0_MG1;
      load_d  = 1'b1;
    end else if (load_q) begin
      cnt_d  = (value == '0) ? CNT_W'(1) : value;
      load_d = 1'b0;
    end else if (one_hz_enable) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = expire_nxt;
        load_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // A request arriving on the S3 entry edge is kept for the next round.
    if (state_d == S3_WALK && state_q != S3_WALK && !WR_Sync)
      walk_d = 1'b0;
  end

  always_comb begin
    interval = IV_BASE;
    LEDs     = 7'b0011000;
    case (state_q)
      S0_MG1:  begin interval = IV_BASE;                          LEDs = 7'b0011000; end
      S1_MG2:  begin interval = Sensor_Sync ? IV_EXT : IV_BASE;   LEDs = 7'b0011000; end
      S2_MY:   begin interval = IV_YEL;                           LEDs = 7'b0101000; end
      S3_WALK: begin interval = IV_EXT;                           LEDs = 7'b1001001; end
      S4_SG1:  begin interval = IV_BASE;                          LEDs = 7'b1000010; end
      S5_SG2:  begin interval = IV_EXT;                           LEDs = 7'b1000010; end
      S6_SY:   begin interval = IV_YEL;                           LEDs = 7'b1000100; end
      default: begin interval = IV_BASE;                          LEDs = 7'b0011000; end
    endcase
    state_dbg    = state_q;
    walk_pending = walk_q;
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase-level reference model checked every cycle,
// directed phase-length scenarios and a randomized run.
`timescale 1ns/1ps
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       Prog_Sync = 1'b0;
  logic       Sensor_Sync = 1'b0;
  logic       WR_Sync = 1'b0;
  logic [3:0] value;
  logic [1:0] interval;
  logic [6:0] LEDs;
  logic       walk_pending;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [3:0] lut [0:2];

  // Reference model: current phase, pending load, remaining pulses, walk latch.
  int m_ph, m_rem, m_v, m_nph;
  bit m_load, m_walk;

  traffic_light_fsm #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .one_hz_enable(one_hz_enable),
    .Prog_Sync(Prog_Sync), .Sensor_Sync(Sensor_Sync), .WR_Sync(WR_Sync),
    .value(value), .interval(interval), .LEDs(LEDs),
    .walk_pending(walk_pending), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // The time-parameter store answers whatever interval is selected.
  always_comb begin
    case (interval)
      2'd0:    value = lut[0];
      2'd1:    value = lut[1];
      2'd2:    value = lut[2];
      default: value = 4'd0;
    endcase
  end

  function automatic int int_of(input int ph, input logic sens);
    case (ph)
      0: return 0;
      1: return sens ? 1 : 0;
      2: return 2;
      3: return 1;
      4: return 0;
      5: return 1;
      6: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] led_of(input int ph);
    case (ph)
      0, 1:    return 7'b0011000;
      2:       return 7'b0101000;
      3:       return 7'b1001001;
      4, 5:    return 7'b1000010;
      6:       return 7'b1000100;
      default: return 7'b0011000;
    endcase
  endfunction

  function automatic int succ(input int ph, input bit walk, input logic sens);
    case (ph)
      0: return 1;
      1: return 2;
      2: return walk ? 3 : 4;
      3: return 4;
      4: return sens ? 5 : 6;
      5: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_load = 1'b1; m_rem = 0; m_walk = 1'b0;
    end else begin
      m_v = int'(lut[int_of(m_ph, Sensor_Sync)]);
      if (m_v == 0) m_v = 1;
      m_nph = m_ph;
      if (Prog_Sync) begin
        m_nph = 0; m_load = 1'b1;
      end else if (m_load) begin
        m_rem = m_v; m_load = 1'b0;
      end else if (one_hz_enable) begin
        if (m_rem <= 1) begin
          m_nph = succ(m_ph, m_walk, Sensor_Sync); m_load = 1'b1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      if (WR_Sync) m_walk = 1'b1;
      else if (m_nph == 3 && m_ph != 3) m_walk = 1'b0;
      m_ph = m_nph;
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      chk("state", int'(state_dbg), m_ph);
      chk("leds", int'(LEDs), int'(led_of(m_ph)));
      chk("interval", int'(interval), int_of(m_ph, Sensor_Sync));
      chk("walk", int'(walk_pending), int'(m_walk));
    end
  end

  // Called on the negedge right after entering st; counts enable pulses until exit.
  task automatic run_phase(input int st, input int exp_p, input int wr_at);
    int n;
    bit done;
    n = 0; done = 1'b0;
    chk("phase_entry", int'(state_dbg), st);
    one_hz_enable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      WR_Sync = (i == wr_at);
      @(negedge clk);
      if (int'(state_dbg) != st) done = 1'b1;
      else n++;
    end
    WR_Sync = 1'b0;
    chk("phase_done", int'(done), 1);
    chk("phase_pulses", n, exp_p);
  endtask

  initial begin
    lut[0] = 4'd6; lut[1] = 4'd3; lut[2] = 4'd2;

    // Reset behaviour
    #1 reset = 1'b1;
    #1;
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_leds", int'(LEDs), 7'b0011000);
    chk("rst_interval", int'(interval), 0);
    chk("rst_walk", int'(walk_pending), 0);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Plain cycle, no sensor, no walk
    run_phase(0, 6, -1); run_phase(1, 6, -1); run_phase(2, 2, -1);
    run_phase(4, 6, -1); run_phase(6, 2, -1);

    // Sensor held high
    Sensor_Sync = 1'b1;
    run_phase(0, 6, -1); run_phase(1, 3, -1); run_phase(2, 2, -1);
    run_phase(4, 6, -1); run_phase(5, 3, -1); run_phase(6, 2, -1);
    Sensor_Sync = 1'b0;

    // Walk request during S0
    run_phase(0, 6, 2);
    chk("walk_latched", int'(walk_pending), 1);
    run_phase(1, 6, -1); run_phase(2, 2, -1);
    chk("walk_cleared", int'(walk_pending), 0);
    chk("walk_leds", int'(LEDs), 7'b1001001);
    run_phase(3, 3, -1); run_phase(4, 6, -1); run_phase(6, 2, -1);
    run_phase(0, 6, -1); run_phase(1, 6, -1); run_phase(2, 2, -1);

    // Reprogram two pulses into S4
    chk("prog_pre_state", int'(state_dbg), 4);
    one_hz_enable = 1'b1; WR_Sync = 1'b1;
    @(negedge clk); WR_Sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Prog_Sync = 1'b1;
    @(negedge clk); Prog_Sync = 1'b0;
    chk("prog_state", int'(state_dbg), 0);
    chk("prog_leds", int'(LEDs), 7'b0011000);
    chk("prog_walk", int'(walk_pending), 1);
    run_phase(0, 6, -1); run_phase(1, 6, -1); run_phase(2, 2, -1);
    run_phase(3, 3, -1); run_phase(4, 6, -1); run_phase(6, 2, -1);

    // Zero yellow length counts as one pulse
    lut[2] = 4'd0;
    run_phase(0, 6, -1); run_phase(1, 6, -1); run_phase(2, 1, -1);
    run_phase(4, 6, -1); run_phase(6, 1, -1);
    lut[2] = 4'd2;

    // Asynchronous reset in the middle of S5
    Sensor_Sync = 1'b1;
    run_phase(0, 6, -1); run_phase(1, 3, -1); run_phase(2, 2, -1);
    run_phase(4, 6, -1);
    chk("s5_entry", int'(state_dbg), 5);
    WR_Sync = 1'b1;
    @(negedge clk); WR_Sync = 1'b0;
    chk("s5_walk", int'(walk_pending), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", int'(state_dbg), 0);
    chk("arst_leds", int'(LEDs), 7'b0011000);
    chk("arst_interval", int'(interval), 0);
    chk("arst_walk", int'(walk_pending), 0);
    @(negedge clk);
    reset = 1'b0;
    Sensor_Sync = 1'b0;
    run_phase(0, 6, -1);

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        lut[0] = 4'($urandom_range(0, 5));
        lut[1] = 4'($urandom_range(0, 5));
        lut[2] = 4'($urandom_range(0, 5));
      end
      one_hz_enable = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) Sensor_Sync = 1'($urandom_range(0, 1));
      WR_Sync   = ($urandom_range(0, 39) == 0);
      Prog_Sync = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    one_hz_enable = 1'b0; WR_Sync = 1'b0; Prog_Sync = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
